// File: rtl/ram_pkg.sv
// Shared types for the byte-enable RAM: FSM state encoding and the legal read-latency range.
package ram_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic bit rd_latency_legal(input int lat);
        return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/ram_be_core.sv
// Simple dual-port storage array: byte-enable write port and registered read port.
// A same-address read and write in one cycle returns the old word (read-first).
module ram_be_core #(
    parameter int ADDR = 12,
    parameter int DATA = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR-1:0]   waddr_i,
    input  logic [DATA-1:0]   wdata_i,
    input  logic [DATA/8-1:0] wbe_i,
    input  logic              re_i,
    input  logic [ADDR-1:0]   raddr_i,
    output logic [DATA-1:0]   rdata_o
);
    localparam int NB    = DATA / 8;
    localparam int DEPTH = 1 << ADDR;

    (* ram_style = "huge" *) logic [DATA-1:0] mem_q [DEPTH];
    logic [DATA-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_inferred_be.sv
// Byte-enable RAM wrapper: CLEAR/READY FSM, write-first collision bypass and 1- or 2-cycle read pipeline.
// The zero-fill sweep and clear_req handling exist only when RAM_INFERRED_BE_CLEAR_EN is defined.
import ram_pkg::*;

module ram_inferred_be #(
    parameter int ADDR        = 12,
    parameter int DATA        = 32,
    parameter int RD_LATENCY  = 1,
    parameter int WRITE_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              ready,
    input  logic              wr_en,
    input  logic [ADDR-1:0]   wr_addr,
    input  logic [DATA-1:0]   wr_data,
    input  logic [DATA/8-1:0] wr_be,
    input  logic              rd_en,
    input  logic [ADDR-1:0]   rd_addr,
    output logic [DATA-1:0]   rd_data,
    output logic              rd_valid
);
    localparam int   NB       = DATA / 8;
    localparam logic WR_FIRST = (WRITE_FIRST != 0);

    if (DATA % 8 != 0) begin : g_bad_data
        $error("ram_inferred_be: DATA (%0d) must be a multiple of 8", DATA);
    end
    if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
        $error("ram_inferred_be: RD_LATENCY (%0d) must be 1 or 2", RD_LATENCY);
    end

    ram_state_e      state_q, state_d;
    logic            wr_ok, rd_ok;
    logic            mem_we;
    logic [ADDR-1:0] mem_waddr;
    logic [DATA-1:0] mem_wdata;
    logic [NB-1:0]   mem_wbe;
    logic [DATA-1:0] mem_rdata;

    assign ready = (state_q == READY);
    assign wr_ok = wr_en & ready;
    assign rd_ok = rd_en & ready;

`ifdef RAM_INFERRED_BE_CLEAR_EN
    logic [ADDR-1:0] sweep_q, sweep_d;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            CLEAR: begin
                sweep_d = sweep_q + ADDR'(1);
                if (sweep_q == '1) state_d = READY;
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                sweep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    // Outside READY the sweep owns the write port; it is held off while rst is high so reset never edits the array.
    assign mem_we    = ready ? wr_en   : ~rst;
    assign mem_waddr = ready ? wr_addr : sweep_q;
    assign mem_wdata = ready ? wr_data : '0;
    assign mem_wbe   = ready ? wr_be   : '1;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;

    always_comb begin
        state_d = READY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= CLEAR;
        else     state_q <= state_d;
    end

    assign mem_we    = wr_ok;
    assign mem_waddr = wr_addr;
    assign mem_wdata = wr_data;
    assign mem_wbe   = wr_be;
`endif

    ram_be_core #(
        .ADDR (ADDR),
        .DATA (DATA)
    ) u_core (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .wbe_i   (mem_wbe),
        .re_i    (rd_ok),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    logic [DATA-1:0] wr_mask;
    logic            collide;
    logic            v1_q;
    logic            byp_q;
    logic [DATA-1:0] byp_data_q, byp_mask_q;
    logic [DATA-1:0] s1_data;

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NB; b++) begin
            wr_mask[b*8 +: 8] = {8{wr_be[b]}};
        end
    end

    assign collide = rd_ok & wr_ok & (rd_addr == wr_addr) & WR_FIRST;

    // Bypass info only reloads with a new read, so it stays aligned with the held core output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            v1_q <= rd_ok;
            if (rd_ok) begin
                byp_q      <= collide;
                byp_data_q <= wr_data;
                byp_mask_q <= wr_mask;
            end
        end
    end

    assign s1_data = byp_q ? ((mem_rdata & ~byp_mask_q) | (byp_data_q & byp_mask_q)) : mem_rdata;

    if (RD_LATENCY == 1) begin : g_lat1
        logic seen_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) seen_q <= 1'b0;
            else     seen_q <= seen_q | v1_q;
        end

        // The core register has no reset, so output is forced to zero until the first read lands.
        assign rd_valid = v1_q;
        assign rd_data  = (seen_q | v1_q) ? s1_data : '0;
    end else begin : g_lat2
        logic            v2_q;
        logic [DATA-1:0] d2_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) d2_q <= s1_data;
            end
        end

        assign rd_valid = v2_q;
        assign rd_data  = d2_q;
    end

endmodule

// File: tb/tb_ram_inferred_be.sv
// Bench for ram_inferred_be: two instances (latency 1 read-first, latency 2 write-first) share one stimulus stream.
// Covers the clear sweep when RAM_INFERRED_BE_CLEAR_EN is defined, the always-ready build otherwise.
module tb_ram_inferred_be;
    localparam int AW = 4;
    localparam int DW = 16;
`ifdef RAM_INFERRED_BE_CLEAR_EN
    localparam int LOW_CYCLES = 16;
`else
    localparam int LOW_CYCLES = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_req = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [1:0]    wr_be = '0;

    logic          ready_a, rd_valid_a, ready_b, rd_valid_b;
    logic [DW-1:0] rd_data_a, rd_data_b;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_a_q[$];
    logic [DW-1:0] exp_b_q[$];
    int            cyc_a_q[$];
    int            cyc_b_q[$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    ram_inferred_be #(.ADDR(AW), .DATA(DW), .RD_LATENCY(1), .WRITE_FIRST(0)) dut_a (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    ram_inferred_be #(.ADDR(AW), .DATA(DW), .RD_LATENCY(2), .WRITE_FIRST(1)) dut_b (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks: one call drives one cycle; a read pushes its expected words for both instances
    task automatic cycle_op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic [1:0] wbe, input logic re, input logic [AW-1:0] ra,
                            input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        @(negedge clk);
        clear_req = 1'b0;
        wr_en = we;   wr_addr = wa;   wr_data = wd;   wr_be = wbe;
        rd_en = re;   rd_addr = ra;
        if (re) begin
            exp_a_q.push_back(ea);  cyc_a_q.push_back(cyc + 1);
            exp_b_q.push_back(eb);  cyc_b_q.push_back(cyc + 2);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        cycle_op(1'b1, a, d, be, 1'b0, 4'd0, 16'h0, 16'h0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        cycle_op(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, a, ea, eb);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle_op(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 16'h0, 16'h0);
    endtask

    // Counts negedges with ready low starting now; with poke set, hammers ignored accesses and a clear_req.
    task automatic wait_ready(input string name, input logic poke);
        int n;
        n = 0;
        while (!ready_a && n < 100) begin
            n++;
            if (poke) begin
                rd_en = 1'b1;  rd_addr = AW'(n);
                wr_en = 1'b1;  wr_addr = 4'd2;  wr_data = 16'hFFFF;  wr_be = 2'b11;
                clear_req = (n == 5);
            end
            @(negedge clk);
        end
        rd_en = 1'b0;  wr_en = 1'b0;  clear_req = 1'b0;
        check_int(name, n, LOW_CYCLES);
        check_int({name, "_b_ready"}, int'(ready_b), 1);
    endtask

    // scoreboard monitors
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_a = '0;
        end else if (rd_valid_a) begin
            if (exp_a_q.size() == 0) begin
                checks++;  errors++;
                $display("FAIL a_unexpected_read: got rd_valid with 0x%h, want no result", rd_data_a);
            end else begin
                check("a_rd_data", rd_data_a, exp_a_q.pop_front());
                check_int("a_latency_cycle", cyc, cyc_a_q.pop_front());
                last_a = rd_data_a;
            end
        end else begin
            check("a_rd_data_hold", rd_data_a, last_a);
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_b = '0;
        end else if (rd_valid_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;  errors++;
                $display("FAIL b_unexpected_read: got rd_valid with 0x%h, want no result", rd_data_b);
            end else begin
                check("b_rd_data", rd_data_b, exp_b_q.pop_front());
                check_int("b_latency_cycle", cyc, cyc_b_q.pop_front());
                last_b = rd_data_b;
            end
        end else begin
            check("b_rd_data_hold", rd_data_b, last_b);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_int("reset_ready_a", int'(ready_a), 0);
        check_int("reset_ready_b", int'(ready_b), 0);
        check_int("reset_valid_a", int'(rd_valid_a), 0);
        check_int("reset_valid_b", int'(rd_valid_b), 0);
        check("reset_data_a", rd_data_a, 16'h0000);
        check("reset_data_b", rd_data_b, 16'h0000);
        rst = 1'b0;
        wait_ready("ready_low_after_reset", 1'b0);

`ifdef RAM_INFERRED_BE_CLEAR_EN
        for (int i = 0; i < 16; i++) rd(AW'(i), 16'h0000, 16'h0000);
`else
        for (int i = 0; i < 16; i++) wr(AW'(i), 16'hA500 | DW'(i), 2'b11);
        for (int i = 0; i < 16; i++) rd(AW'(i), 16'hA500 | DW'(i), 16'hA500 | DW'(i));
`endif

        // byte enables
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        rd(4'd3, 16'h12CD, 16'h12CD);
        wr(4'd3, 16'hFFFF, 2'b00);
        rd(4'd3, 16'h12CD, 16'h12CD);
        wr(4'd3, 16'hEE00, 2'b10);
        rd(4'd3, 16'hEECD, 16'hEECD);

        // same-address collisions: full word, then a single byte
        wr(4'd5, 16'h1111, 2'b11);
        cycle_op(1'b1, 4'd5, 16'h2222, 2'b11, 1'b1, 4'd5, 16'h1111, 16'h2222);
        rd(4'd5, 16'h2222, 16'h2222);
        wr(4'd6, 16'h3344, 2'b11);
        cycle_op(1'b1, 4'd6, 16'hAABB, 2'b01, 1'b1, 4'd6, 16'h3344, 16'h33BB);
        rd(4'd6, 16'h33BB, 16'h33BB);

        // different addresses in one cycle, then back-to-back reads
        cycle_op(1'b1, 4'd7, 16'h5566, 2'b11, 1'b1, 4'd3, 16'hEECD, 16'hEECD);
        rd(4'd7, 16'h5566, 16'h5566);
        rd(4'd3, 16'hEECD, 16'hEECD);
        rd(4'd5, 16'h2222, 16'h2222);
        rd(4'd6, 16'h33BB, 16'h33BB);
        rd(4'd7, 16'h5566, 16'h5566);
        idle(4);

`ifdef RAM_INFERRED_BE_CLEAR_EN
        // reset while the sweep is at address 7
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_int("midsweep_rst_valid_a", int'(rd_valid_a), 0);
        check_int("midsweep_rst_valid_b", int'(rd_valid_b), 0);
        check("midsweep_rst_data_a", rd_data_a, 16'h0000);
        check("midsweep_rst_data_b", rd_data_b, 16'h0000);
        check_int("midsweep_rst_ready", int'(ready_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready_low_after_midsweep_reset", 1'b0);
        for (int i = 0; i < 16; i++) rd(AW'(i), 16'h0000, 16'h0000);

        // clear_req with reads in flight; accesses during the sweep are ignored
        wr(4'd3, 16'h0BAD, 2'b11);
        wr(4'd5, 16'h0C0D, 2'b11);
        rd(4'd3, 16'h0BAD, 16'h0BAD);
        rd(4'd5, 16'h0C0D, 16'h0C0D);
        clear_req = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        clear_req = 1'b0;
        wait_ready("ready_low_during_clear", 1'b1);
        for (int i = 0; i < 16; i++) rd(AW'(i), 16'h0000, 16'h0000);
`else
        // clear_req has no effect in this build
        idle(1);
        clear_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            check_int("ready_ignores_clear_req", int'(ready_a), 1);
        end
        rd(4'd3, 16'hEECD, 16'hEECD);
        rd(4'd7, 16'h5566, 16'h5566);
        idle(4);

        // rst clears outputs but not the array
        #2 rst = 1'b1;
        #1;
        check_int("rst_valid_a", int'(rd_valid_a), 0);
        check_int("rst_valid_b", int'(rd_valid_b), 0);
        check("rst_data_a", rd_data_a, 16'h0000);
        check("rst_data_b", rd_data_b, 16'h0000);
        check_int("rst_ready", int'(ready_a), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("ready_low_after_second_reset", 1'b0);
        rd(4'd3, 16'hEECD, 16'hEECD);
        rd(4'd5, 16'h2222, 16'h2222);
`endif

        idle(6);
        check_int("a_pending_reads", exp_a_q.size(), 0);
        check_int("b_pending_reads", exp_b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_inferred_be.md
RAM_INFERRED_BE -- requirements
Module: ram_inferred_be

Interface
REQ-001 The block SHALL have parameter ADDR, default 12, giving the address width; depth is 2**ADDR words.
REQ-002 The block SHALL have parameter DATA, default 32, giving the word width; DATA SHALL be a multiple of 8, and elaboration SHALL fail otherwise.
REQ-003 The block SHALL have parameter RD_LATENCY, default 1, giving read latency in cycles; legal values are 1 and 2.
REQ-004 The block SHALL have parameter WRITE_FIRST, default 0: 0 is read-first collision behaviour, 1 is write-first.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 clear_req  input  1  pulse that requests a zero-fill of the whole array.
REQ-008 ready  output  1  array is accessible; high outside the clear sweep.
REQ-009 wr_en  input  1  write strobe.
REQ-010 wr_addr  input  ADDR  write address.
REQ-011 wr_data  input  DATA  write data.
REQ-012 wr_be  input  DATA/8  byte enables; bit i qualifies wr_data[8i+7:8i].
REQ-013 rd_en  input  1  read strobe.
REQ-014 rd_addr  input  ADDR  read address.
REQ-015 rd_data  output  DATA  read data.
REQ-016 rd_valid  output  1  rd_data carries the result of a read accepted RD_LATENCY cycles earlier.

Function
REQ-017 The block SHALL implement an FSM with states CLEAR and READY; ready SHALL be 1 only in READY.
REQ-018 In CLEAR, the block SHALL write all-zero to one address per cycle, from 0 to 2**ADDR-1, then enter READY on the following cycle.
REQ-019 In READY, clear_req=1 SHALL enter CLEAR with the sweep counter reset to 0; clear_req SHALL be ignored in CLEAR.
REQ-020 wr_en and rd_en SHALL be ignored while ready=0; an ignored read SHALL produce no rd_valid.
REQ-021 A write in READY SHALL update only the bytes whose wr_be bit is 1; wr_be of all zero SHALL leave the word unchanged.
REQ-022 A read accepted at cycle N SHALL present data with rd_valid=1 at cycle N+RD_LATENCY; back-to-back reads SHALL sustain one result per cycle.
REQ-023 rd_data SHALL hold its last value whenever rd_valid=0.
REQ-024 When a read and a write target the same address in the same cycle and WRITE_FIRST=0, the read SHALL return the pre-write word.
REQ-025 Under the same collision with WRITE_FIRST=1, the read SHALL return the merged word: enabled bytes from wr_data, other bytes from the old word.
REQ-026 Reads and writes to different addresses in the same cycle SHALL both complete with no interaction.
REQ-027 A clear_req that arrives while reads are in flight SHALL still deliver the pending reads; new reads are blocked from the next cycle.

Reset
REQ-028 Asserting rst SHALL asynchronously force ready=0, rd_valid=0, rd_data=0, all pipeline valids to 0, and the sweep counter to 0.
REQ-029 On rst deassertion, the FSM SHALL start in CLEAR; an rst during a sweep SHALL restart the sweep at address 0.
REQ-030 Array contents SHALL NOT be reset by rst directly; only the sweep zeroes them.

Configuration
REQ-031 With macro RAM_INFERRED_BE_CLEAR_EN defined, the clear sweep and clear_req SHALL behave as in REQ-017 to REQ-019 and REQ-029.
REQ-032 Without RAM_INFERRED_BE_CLEAR_EN, the block SHALL omit the sweep logic, ignore clear_req, raise ready on the first clock after rst deassertion, and leave array contents undefined.

Structure
REQ-033 Package ram_pkg SHALL hold the FSM state enum (CLEAR, READY) and the RD_LATENCY legality constants.
REQ-034 Storage SHALL be a sub-module ram_be_core: a simple dual-port array with byte-enable write and registered read, carrying ram_style="huge".
REQ-035 The FSM, the collision bypass and the latency pipeline SHALL live in the top level.

Verification (ADDR=4, DATA=16, clear enabled unless stated)
REQ-036 Release rst -> ready=0 for exactly 16 cycles, then ready=1; reads of addresses 0 to 15 all return 0x0000.
REQ-037 Write 0xABCD to address 3 with wr_be=2'b01, after address 3 already holds 0x1234 -> a read of address 3 returns 0x12CD, with rd_valid exactly RD_LATENCY cycles after rd_en, for both RD_LATENCY=1 and RD_LATENCY=2.
REQ-038 Address 5 holds 0x1111; same-cycle write of 0x2222 with wr_be=2'b11 and read of address 5 -> returns 0x1111 when WRITE_FIRST=0, 0x2222 when WRITE_FIRST=1; the next read returns 0x2222.
REQ-039 Assert rst at sweep address 7 -> rd_valid=0 and rd_data=0 immediately; after release, the sweep runs the full 16 cycles from address 0.
REQ-040 Pulse clear_req with 2 reads in flight at RD_LATENCY=2 -> both reads complete; rd_en is ignored during the 16-cycle sweep; all words then read 0.
REQ-041 Build without the macro and pulse clear_req -> ready=1 one cycle after rst release, ready stays 1, and written data survives.
